// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register bank with a registered read port and a
// clear sequencer that walks every word to CLEAR_VAL.
//
// Optional build macro: RAM8_WRITE_THROUGH_EN
//   defined   - a same-cycle load and rd_en returns the new data (in) on out
//   undefined - read-before-write, so out returns the old word
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (all words, out and FSM to 0)
//   in        write data
//   address   word select for both write and read
//   load      write strobe, writes in to word[address] at clk rise
//   rd_en     read request for word[address]
//   clear     starts the 8-cycle clear sequence (pulse or level)
//   busy      high while the clear sequence runs
//   out       registered read data, holds until the next accepted read
//   out_valid one-cycle pulse when out holds fresh read data
module ram8_bank #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             rd_en,
    input  logic             clear,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [WIDTH-1:0] words [8];

    logic [7:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;

    // NOTE: every signal gets a default at the top of the block so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_sel   = '0;
        wr_data  = in;
        rd_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    // Clear wins: same-cycle load and rd_en are discarded.
                    state_nx = CLEAR;
                    cnt_nx   = 3'd0;
                end else begin
                    wr_sel = load ? (8'b1 << address) : 8'b0;
                    rd_ok  = rd_en;
                end
            end
            CLEAR: begin
                wr_sel  = 8'b1 << cnt;
                wr_data = CLEAR_VAL;
                cnt_nx  = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only one address port exists, so a load and a read in the same cycle
    // always target the same word.
`ifdef RAM8_WRITE_THROUGH_EN
    assign rd_data = load ? in : words[address];
`else
    assign rd_data = words[address];
`endif

    assign busy = (state == CLEAR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes read-before-write work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= rd_ok;
            if (rd_ok) begin
                out <= rd_data;
            end
        end
    end

    // NOTE: the storage words are reset explicitly because reset must leave
    // every word at 0; this is a flop array, not an inferred RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) begin
                    words[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: self-checking bench for ram8_bank (WIDTH=16, CLEAR_VAL=0x00FF).
// A behavioural model (word array plus a "clear cycles left" count) predicts
// out, out_valid and busy; directed scenarios also compare against constants.
module tb_ram8_bank;

    localparam int          W  = 16;
    localparam logic [15:0] CV = 16'h00FF;
`ifdef RAM8_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [2:0]  address;
    logic        load;
    logic        rd_en;
    logic        clear;
    logic        busy;
    logic [15:0] dout;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] m_mem [8];
    logic [15:0] m_out;
    logic        m_valid;
    int          clear_left;

    ram8_bank #(.WIDTH(W), .CLEAR_VAL(CV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .address   (address),
        .load      (load),
        .rd_en     (rd_en),
        .clear     (clear),
        .busy      (busy),
        .out       (dout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_out      = 16'h0000;
        m_valid    = 1'b0;
        clear_left = 0;
    endtask

    task automatic idle_inputs();
        din     = 16'h0000;
        address = 3'd0;
        load    = 1'b0;
        rd_en   = 1'b0;
        clear   = 1'b0;
    endtask

    // Advance one clock edge, updating the model from the inputs the DUT sees.
    task automatic tick();
        if (clear_left > 0) begin
            m_mem[3'(8 - clear_left)] = CV;
            clear_left--;
            m_valid = 1'b0;
        end else if (clear) begin
            clear_left = 8;
            m_valid    = 1'b0;
        end else begin
            if (rd_en) begin
                m_out   = (WT && load) ? din : m_mem[address];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (load) m_mem[address] = din;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        idle_inputs();
        address = a; din = d; load = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic read_expect(input logic [2:0] a, input logic [15:0] exp, input string tag);
        idle_inputs();
        address = a; rd_en = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || dout !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d: got out=%h valid=%b, expected out=%h valid=1",
                     tag, a, dout, out_valid, exp);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Counts cycles with busy high after a clear is accepted, bounded.
    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            n++;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_no_valid cycle=%0d: got out_valid=%b, expected 0", n, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int pulses;
        do_reset();
        checks++;
        if (dout !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%h valid=%b busy=%b, expected 0 0 0",
                     dout, out_valid, busy);
        end
        pulses = 0;
        for (int a = 0; a < 8; a++) begin
            read_expect(3'(a), 16'h0000, "reset_read");
            if (out_valid === 1'b1) pulses++;
        end
        tick();
        if (out_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL reset_read_pulses: got %0d pulses, expected 8", pulses);
        end
    endtask

    task automatic test_write_read_sweep();
        for (int a = 7; a >= 0; a--) write_word(3'(a), 16'(16'h1111 * (a + 1)));
        for (int a = 0; a < 8; a++) read_expect(3'(a), 16'(16'h1111 * (a + 1)), "sweep_read");
    endtask

    task automatic test_collision();
        logic [15:0] exp;
        write_word(3'd5, 16'hAAAA);
        idle_inputs();
        address = 3'd5; din = 16'h5555; load = 1'b1; rd_en = 1'b1;
        tick();
        idle_inputs();
        exp = WT ? 16'h5555 : 16'hAAAA;
        checks++;
        if (out_valid !== 1'b1 || dout !== exp) begin
            errors++;
            $display("FAIL collision_read: got out=%h valid=%b, expected out=%h valid=1",
                     dout, out_valid, exp);
        end
        read_expect(3'd5, 16'h5555, "collision_after");
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 8; a++) write_word(3'(a), 16'hBEEF);
        idle_inputs();
        clear = 1'b1;
        tick();
        idle_inputs();
        // Hold a load to word 3 for the entire busy window; it must be dropped.
        address = 3'd3; din = 16'h1234; load = 1'b1; rd_en = 1'b1;
        measure_busy(n);
        idle_inputs();
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d cycles, expected 8", n);
        end
        for (int a = 0; a < 8; a++) read_expect(3'(a), CV, "clear_read");
    endtask

    task automatic test_clear_priority();
        int n;
        write_word(3'd2, 16'h4444);
        idle_inputs();
        clear = 1'b1; load = 1'b1; rd_en = 1'b1; address = 3'd2; din = 16'h7777;
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_prio_accept: got valid=%b busy=%b, expected valid=0 busy=1",
                     out_valid, busy);
        end
        measure_busy(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL clear_prio_busy_len: got %0d cycles, expected 8", n);
        end
        read_expect(3'd2, CV, "clear_prio_word2");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        for (int a = 0; a < 8; a++) write_word(3'(a), 16'hBEEF);
        read_expect(3'd1, 16'hBEEF, "midclr_preread");
        clear = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();   // now in the 4th busy cycle
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (busy !== 1'b0 || dout !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midclr_reset_now: got busy=%b out=%h valid=%b, expected 0 0000 0",
                     busy, dout, out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 8; a++) read_expect(3'(a), 16'h0000, "midclr_read");
        clear = 1'b1;
        tick();
        idle_inputs();
        measure_busy(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL midclr_next_clear_len: got %0d cycles, expected 8", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din     = 16'($urandom);
            address = 3'($urandom_range(0, 7));
            load    = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            clear   = ($urandom_range(0, 31) == 0);
            tick();
            checks++;
            if (out_valid !== m_valid || dout !== m_out || busy !== (clear_left > 0)) begin
                errors++;
                $display("FAIL random cycle=%0d: got out=%h valid=%b busy=%b, expected out=%h valid=%b busy=%b",
                         i, dout, out_valid, busy, m_out, m_valid, clear_left > 0);
            end
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        for (int a = 0; a < 8; a++) read_expect(3'(a), m_mem[a], "random_final");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read_sweep();
        test_collision();
        test_clear();
        test_clear_priority();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
